// File: rtl/cic3_conv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic3_pkg : shared types and constants for the CIC3 conversion ctrl   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cic3_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } cic3_ctrl_state_t;

    localparam int CIC3_FLUSH_CYCLES   = 2;
    localparam int CIC3_SETTLE_SAMPLES = 3;

endpackage
`default_nettype wire

// File: rtl/cic3_conv_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic3_conv_ctrl_if : valid/ready sample handshake toward readout      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface cic3_conv_ctrl_if #(
    parameter int NUMBITS = 25
) ();
    logic [NUMBITS-1:0] sample_data;
    logic               sample_valid;
    logic               sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface
`default_nettype wire

// File: rtl/cic3_conv_ctrl_clkgen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic3_decim_clkgen : falling-edge decimation counter, divided clock   |
// | and registered capture strobe.                        Rev 1.0        |
// +----------------------------------------------------------------------+
module cic3_decim_clkgen #(
    parameter int CLOCK_WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic cnt_en,
    output logic      divided_clk,
    output logic      strobe
);

    logic [CLOCK_WIDTH-1:0] r_cnt;
    logic                   r_dclk_d;
    logic                   r_strobe;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (cnt_en) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Edge detected here, consumed one clk later so the filter output stages have settled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dclk_d <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_dclk_d <= r_cnt[CLOCK_WIDTH-1];
            r_strobe <= r_cnt[CLOCK_WIDTH-1] & ~r_dclk_d;
        end
    end

    assign divided_clk = r_cnt[CLOCK_WIDTH-1];
    assign strobe      = r_strobe;

endmodule
`default_nettype wire

// File: rtl/cic3_conv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic3_conv_ctrl : CIC3 conversion sequencer (flush, settle, capture)  |
// | Optional CIC3_CTRL_OVERRUN_CNT_EN adds overrun_cnt[7:0].  Rev 1.0    |
// +----------------------------------------------------------------------+
module cic3_conv_ctrl
    import cic3_pkg::*;
#(
    parameter int DECIMATION_FACTOR = 256,
    parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int NUMBITS           = 3*CLOCK_WIDTH+1,
    parameter int SETTLE_SAMPLES    = CIC3_SETTLE_SAMPLES,
    parameter int BURST_WIDTH       = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic                   start,
    input  wire logic                   stop,
    input  wire logic                   continuous,
    input  wire logic [BURST_WIDTH-1:0] burst_len,
    input  wire logic [NUMBITS-1:0]     filt_data,
    output logic                        divided_clk,
    output logic                        filt_reset_n,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun,
`ifdef CIC3_CTRL_OVERRUN_CNT_EN
    output logic [7:0]                  overrun_cnt,
`endif
    cic3_conv_ctrl_if.master            smp
);

    localparam int c_FLUSH_W  = (CIC3_FLUSH_CYCLES > 1) ? $clog2(CIC3_FLUSH_CYCLES) : 1;
    localparam int c_SETTLE_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

    cic3_ctrl_state_t        r_state;
    logic [c_FLUSH_W-1:0]    r_flush_cnt;
    logic [c_SETTLE_W-1:0]   r_settle_cnt;
    logic [BURST_WIDTH-1:0]  r_burst_cnt;
    logic [BURST_WIDTH-1:0]  r_burst_last;
    logic                    r_continuous;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_filt_reset_n;
    logic [NUMBITS-1:0]      r_sample_data;
    logic                    r_sample_valid;
    logic                    r_overrun;
`ifdef CIC3_CTRL_OVERRUN_CNT_EN
    logic [7:0]              r_overrun_cnt;
`endif

    logic                    w_cnt_en;
    logic                    w_strobe;
    logic                    w_capture;
    logic [BURST_WIDTH-1:0]  w_len_eff;

    assign w_cnt_en  = (r_state != IDLE) && (r_state != FLUSH);
    assign w_capture = (r_state == RUN) && w_strobe && !stop;
    assign w_len_eff = (burst_len == '0) ? BURST_WIDTH'(1) : burst_len;

    cic3_decim_clkgen #(
        .CLOCK_WIDTH (CLOCK_WIDTH)
    ) u_clkgen (
        .clk         (clk),
        .reset_n     (reset_n),
        .cnt_en      (w_cnt_en),
        .divided_clk (divided_clk),
        .strobe      (w_strobe)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_flush_cnt    <= '0;
            r_settle_cnt   <= '0;
            r_burst_cnt    <= '0;
            r_burst_last   <= '0;
            r_continuous   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_filt_reset_n <= 1'b1;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
`ifdef CIC3_CTRL_OVERRUN_CNT_EN
            r_overrun_cnt  <= '0;
`endif
        end else begin
            r_busy         <= (r_state != IDLE);
            r_done         <= (r_state == DONE);
            r_filt_reset_n <= (r_state != FLUSH);

            // A capture into a word nobody has taken yet is lost, not queued.
            if (w_capture) begin
                if (!r_sample_valid || smp.sample_ready) begin
                    r_sample_data  <= filt_data;
                    r_sample_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
`ifdef CIC3_CTRL_OVERRUN_CNT_EN
                    if (r_overrun_cnt != 8'hFF) begin
                        r_overrun_cnt <= r_overrun_cnt + 8'd1;
                    end
`endif
                end
            end else if (smp.sample_ready) begin
                r_sample_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_continuous <= continuous;
                        r_burst_last <= w_len_eff - BURST_WIDTH'(1);
                        r_burst_cnt  <= '0;
                        r_flush_cnt  <= '0;
                        r_settle_cnt <= '0;
                        r_overrun    <= 1'b0;
`ifdef CIC3_CTRL_OVERRUN_CNT_EN
                        r_overrun_cnt <= '0;
`endif
                        r_state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (stop) begin
                        r_state <= DONE;
                    end else if (r_flush_cnt == c_FLUSH_W'(CIC3_FLUSH_CYCLES-1)) begin
                        r_state <= SETTLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (stop) begin
                        r_state <= DONE;
                    end else if (w_strobe) begin
                        if (r_settle_cnt == c_SETTLE_W'(SETTLE_SAMPLES-1)) begin
                            r_state <= RUN;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= DONE;
                    end else if (w_strobe && !r_continuous) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (r_burst_cnt == r_burst_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign filt_reset_n     = r_filt_reset_n;
    assign busy             = r_busy;
    assign done             = r_done;
    assign overrun          = r_overrun;
    assign smp.sample_data  = r_sample_data;
    assign smp.sample_valid = r_sample_valid;
`ifdef CIC3_CTRL_OVERRUN_CNT_EN
    assign overrun_cnt      = r_overrun_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/cic3_conv_ctrl.md
# cic3_conv_ctrl

Conversion sequencer for the third-order CIC decimator. It generates the decimation clock (`divided_clk`) and pulses the filter reset at conversion start. It discards the filter's settling outputs, then captures each decimated word into a holding register offered on a valid/ready handshake. It sits between the CIC filter instance and the readout/register-bank logic, and runs single-shot bursts or continuous conversion.

## Interface
- `DECIMATION_FACTOR`, 256, decimation ratio D (power of two, ≥4)
- `CLOCK_WIDTH`, `$clog2(DECIMATION_FACTOR)`, decimation counter width
- `NUMBITS`, `3*CLOCK_WIDTH+1`, filter word width
- `SETTLE_SAMPLES`, 3, decimated outputs discarded after filter reset
- `BURST_WIDTH`, 16, burst length counter width
- `clk` in 1: high-speed modulator clock, same as the filter's
- `reset_n` in 1: asynchronous reset, active low
- `start` in 1: begin conversion, sampled in IDLE only
- `stop` in 1: abort conversion
- `continuous` in 1: 1 = run until `stop`; 0 = burst of `burst_len` samples; sampled with `start`
- `burst_len` in BURST_WIDTH: samples per burst; 0 treated as 1; sampled with `start`
- `filt_data` in NUMBITS: filter `out`
- `divided_clk` out 1: decimation clock to the filter
- `filt_reset_n` out 1: filter reset, registered, active low
- `sample_data` out NUMBITS: held sample
- `sample_valid` out 1: `sample_data` valid
- `sample_ready` in 1: consumer accepts
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse on conversion end
- `overrun` out 1: sticky; cleared on accepted `start`

## Operation
- Reset values: `divided_clk`=0, `filt_reset_n`=1, `sample_data`=0, `sample_valid`=0, `busy`=0, `done`=0, `overrun`=0. State = IDLE. Counters = 0.
- Decimation counter `cnt[CLOCK_WIDTH-1:0]` updates on the falling edge of `clk`.
  - `divided_clk` = `cnt` MSB.
  - `cnt` is held at 0 while the state is IDLE or FLUSH; otherwise it increments and wraps at D.
- Capture strobe: rising edge of `divided_clk`, detected on the rising edge of `clk`, is registered one more cycle. This guarantees that `filt_data` has passed through the filter's two output stages.
- States (rising edge of `clk`):
  - IDLE: on `start`, latch `continuous` and `burst_len`, clear `overrun`, go to FLUSH.
  - FLUSH: `filt_reset_n`=0 for exactly 2 cycles, then SETTLE.
  - SETTLE: count capture strobes. After SETTLE_SAMPLES strobes, go to RUN. Discarded strobes never touch `sample_valid`.
  - RUN: each strobe is a capture, and the burst counter increments. In burst mode, the capture that reaches the latched length goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `stop` in FLUSH, SETTLE or RUN goes to DONE on the next edge. `stop` has priority over a same-cycle capture, which is dropped. `stop` in IDLE or DONE is ignored.
- `start` outside IDLE is ignored.
- Handshake:
  - A capture with `sample_valid`=0, or with `sample_valid`=1 and `sample_ready`=1 on the same cycle, loads `sample_data` and sets `sample_valid`=1.
  - A capture with `sample_valid`=1 and `sample_ready`=0 drops the new word, keeps the old word, and sets `overrun`.
  - `sample_ready` with no capture clears `sample_valid`.
- A held sample survives DONE and IDLE until accepted. A new `start` does not clear it.
- The burst counter is BURST_WIDTH bits. It counts captures including dropped ones, and does not count in continuous mode.

## Timing
- Latency, with `start` sampled at edge T0:
  - FLUSH spans T1–T2; SETTLE is entered at T2.
  - The k-th strobe (k ≥ 1) fires at T0 + 3 + D/2 + (k−1)·D.
  - The first delivered sample is valid after edge T0 + 3 + D/2 + SETTLE_SAMPLES·D.
  - Subsequent samples follow every D cycles.
- `done` is asserted the cycle after the final capture or after `stop` is registered.
- Reset mid-operation returns all outputs to their reset values asynchronously; any held sample is lost.

## Configuration
- `CIC3_CTRL_OVERRUN_CNT_EN` defined: adds output `overrun_cnt` [7:0], which counts dropped captures, saturates at 255, and is cleared on accepted `start` and on reset.
- Undefined: the port is absent and only the sticky `overrun` flag exists.

## Structure
- Shared package `cic3_pkg`:
  - state enum `cic3_ctrl_state_t` (IDLE, FLUSH, SETTLE, RUN, DONE)
  - constant `CIC3_FLUSH_CYCLES` = 2
  - default `CIC3_SETTLE_SAMPLES` = 3
- One sub-module, `cic3_decim_clkgen`: the falling-edge counter, `divided_clk`, and the registered capture strobe. The FSM and handshake stay in the top.

## Test plan
All scenarios use D=8 and SETTLE_SAMPLES=3.
- Reset with `reset_n`=0: all outputs at reset values; `divided_clk` stays 0 while IDLE.
- Burst: `burst_len`=2, `continuous`=0, `start` at T0.
  - `filt_reset_n` is low at T1–T2 only.
  - `sample_valid` rises after T31 and T39, with `sample_ready`=1.
  - `done` pulses at T40; `busy` falls at T41.
- Overrun: continuous mode, `sample_ready`=0.
  - First word is held; second capture sets `overrun` and leaves `sample_data` unchanged.
  - With the macro defined, `overrun_cnt`=1.
- Simultaneous: `sample_ready`=1 exactly on a capture edge with a held word. New word loads, `sample_valid` stays 1, `overrun` stays 0.
- Abort: `stop` during SETTLE. Next cycle is DONE and `done` pulses; no sample is produced. A `start` during DONE is ignored.
- `burst_len`=0: exactly one sample is delivered, then `done`.
